// File: rtl/ac97_reg_arbiter_pkg.sv
// ac97_pkg: slot field positions, codec register indices and arbiter state encoding
package ac97_pkg;
  localparam int SLOT_RW_BIT  = 19;
  localparam int SLOT_ADDR_HI = 18;
  localparam int SLOT_ADDR_LO = 12;
  localparam int SLOT_DATA_HI = 19;
  localparam int SLOT_DATA_LO = 4;
  localparam logic [6:0] AC97_REG_RESET = 7'h00;
  localparam logic [6:0] MASTER_VOL     = 7'h02;
  localparam logic [6:0] PCM_VOL        = 7'h18;
  localparam logic [6:0] POWERDOWN      = 7'h26;
  localparam logic [6:0] VID0           = 7'h7C;
  localparam logic [6:0] VID1           = 7'h7E;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  // Command address slot: bit 19 set means read.
  function automatic logic [19:0] slot1_enc(input logic wr, input logic [6:0] addr);
    return {~wr, addr, 12'h000};
  endfunction
endpackage

// File: rtl/ac97_reg_arbiter_if.sv
// ac97_reg_arbiter_if: requester-side register command bus shared by both requesters
interface ac97_reg_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [6:0]  req_addr0;
  logic [6:0]  req_addr1;
  logic [15:0] req_wdata0;
  logic [15:0] req_wdata1;
  logic [1:0]  done;
  logic        err;
  logic [15:0] rdata;
  modport master (output req, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
                  input done, err, rdata);
  modport slave  (input req, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
                  output done, err, rdata);
endinterface

// File: rtl/ac97_reg_arbiter_rr_arb2.sv
// ac97_rr_arb2: two-way round-robin grant; on contention the requester other than last wins
module ac97_rr_arb2 (
  input  logic       ac97_bitclk,
  input  logic       ac97_rst_b,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt
);
  logic last;
  assign gnt = &req ? ~last : req[1];
  // Remember the most recent grant so the other requester wins the next tie.
  always_ff @(posedge ac97_bitclk or negedge ac97_rst_b)
    if (!ac97_rst_b) last <= 1'b1;
    else if (en) last <= gnt;
endmodule

// File: rtl/ac97_reg_arbiter.sv
// ac97_reg_arbiter: shares the AC-link register command slots between two requesters, one command per frame
module ac97_reg_arbiter
  import ac97_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        ac97_bitclk,
  input  logic        ac97_rst_b,
  input  logic        ac97_strobe,
  ac97_reg_arbiter_if.slave rif,
  output logic [19:0] ac97_out_slot1,
  output logic        ac97_out_slot1_valid,
  output logic [19:0] ac97_out_slot2,
  output logic        ac97_out_slot2_valid,
  input  logic [19:0] ac97_in_slot1,
  input  logic        ac97_in_slot1_valid,
  input  logic [19:0] ac97_in_slot2,
  input  logic        ac97_in_slot2_valid
);
  state_t      state;
  logic        g;
  logic        wr;
  logic [6:0]  addr;
  logic [3:0]  cnt;
  logic        gnt;
  logic        sel_wr;
  logic [6:0]  sel_addr;
  logic [15:0] sel_wdata;
  logic        hit;
  logic        unused_bits;
  assign sel_wr      = rif.req_wr[gnt];
  assign sel_addr    = gnt ? rif.req_addr1 : rif.req_addr0;
  assign sel_wdata   = gnt ? rif.req_wdata1 : rif.req_wdata0;
  assign hit         = ac97_in_slot1_valid && ac97_in_slot2_valid &&
                       ac97_in_slot1[SLOT_ADDR_HI:SLOT_ADDR_LO] == addr;
  assign unused_bits = ^{ac97_in_slot1[SLOT_RW_BIT], ac97_in_slot1[SLOT_ADDR_LO-1:0],
                         ac97_in_slot2[SLOT_DATA_LO-1:0]};
  ac97_rr_arb2 u_arb (
    .ac97_bitclk(ac97_bitclk),
    .ac97_rst_b (ac97_rst_b),
    .req        (rif.req),
    .en         (ac97_strobe && state == IDLE && |rif.req),
    .gnt        (gnt)
  );
  // Frame-aligned command FSM: all state and outputs move only on strobe edges except the done pulse clear.
  always_ff @(posedge ac97_bitclk or negedge ac97_rst_b)
    if (!ac97_rst_b) begin
      state                <= IDLE;
      g                    <= 1'b0;
      wr                   <= 1'b0;
      addr                 <= '0;
      cnt                  <= '0;
      rif.done             <= '0;
      rif.err              <= 1'b0;
      rif.rdata            <= '0;
      ac97_out_slot1       <= '0;
      ac97_out_slot1_valid <= 1'b0;
      ac97_out_slot2       <= '0;
      ac97_out_slot2_valid <= 1'b0;
    end else begin
      rif.done <= '0;
      if (ac97_strobe)
        case (state)
          IDLE: if (|rif.req) begin
            g                    <= gnt;
            wr                   <= sel_wr;
            addr                 <= sel_addr;
            ac97_out_slot1       <= slot1_enc(sel_wr, sel_addr);
            ac97_out_slot1_valid <= 1'b1;
            ac97_out_slot2       <= sel_wr ? {sel_wdata, 4'h0} : 20'h0;
            ac97_out_slot2_valid <= sel_wr;
            state                <= ISSUE;
          end
          ISSUE: begin
            ac97_out_slot1       <= '0;
            ac97_out_slot1_valid <= 1'b0;
            ac97_out_slot2       <= '0;
            ac97_out_slot2_valid <= 1'b0;
            if (wr) begin
              rif.done[g] <= 1'b1;
              rif.err     <= 1'b0;
              state       <= IDLE;
            end else begin
              cnt   <= 4'(TIMEOUT_FRAMES);
              state <= WAIT_RD;
            end
          end
          WAIT_RD: if (hit) begin
            rif.done[g] <= 1'b1;
            rif.err     <= 1'b0;
            rif.rdata   <= ac97_in_slot2[SLOT_DATA_HI:SLOT_DATA_LO];
            cnt         <= '0;
            state       <= IDLE;
          end else if (cnt == 4'd1) begin
            rif.done[g] <= 1'b1;
            rif.err     <= 1'b1;
            rif.rdata   <= '0;
            cnt         <= '0;
            state       <= IDLE;
          end else cnt <= cnt - 4'd1;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_ac97_reg_arbiter.sv
// tb_ac97_reg_arbiter: directed and randomized bench with a frame-counting transaction model
module tb_ac97_reg_arbiter;
  import ac97_pkg::*;
  localparam int TO = 4;
  localparam int FR = 32;
  logic clk = 0, rst_n = 0, strobe = 0;
  logic [19:0] s1, s2, in1 = 0, in2 = 0;
  logic s1v, s2v, in1v = 0, in2v = 0;
  ac97_reg_arbiter_if ifc();
  ac97_reg_arbiter #(.TIMEOUT_FRAMES(TO)) dut (
    .ac97_bitclk(clk), .ac97_rst_b(rst_n), .ac97_strobe(strobe), .rif(ifc),
    .ac97_out_slot1(s1), .ac97_out_slot1_valid(s1v),
    .ac97_out_slot2(s2), .ac97_out_slot2_valid(s2v),
    .ac97_in_slot1(in1), .ac97_in_slot1_valid(in1v),
    .ac97_in_slot2(in2), .ac97_in_slot2_valid(in2v));
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic expire(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask
  // transaction model: counts strobes since the grant
  logic [1:0] e_done;
  logic e_err, e_s1v, e_s2v;
  logic [15:0] e_rdata;
  logic [19:0] e_s1, e_s2;
  bit busy, m_wr;
  int n, mg, mlast;
  logic [6:0] m_addr;
  logic [15:0] m_wdata;
  task automatic finish_m(input logic er, input logic [15:0] rd);
    e_done = '0;
    e_done[mg] = 1'b1;
    e_err = er;
    e_rdata = rd;
    busy = 0;
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      e_done = 0; e_err = 0; e_rdata = 0; e_s1 = 0; e_s2 = 0; e_s1v = 0; e_s2v = 0;
      busy = 0; n = 0; mlast = 1; mg = 0;
    end else begin
      e_done = 0;
      if (strobe) begin
        if (busy) begin
          n++;
          if (n == 1) begin
            e_s1 = 0; e_s1v = 0; e_s2 = 0; e_s2v = 0;
            if (m_wr) finish_m(1'b0, e_rdata);
          end else if (in1v && in2v && in1[18:12] == m_addr) finish_m(1'b0, in2[19:4]);
          else if (n == TO + 1) finish_m(1'b1, 16'h0);
        end else if (ifc.req != 0) begin
          mg = (ifc.req == 2'b11) ? 1 - mlast : (ifc.req[1] ? 1 : 0);
          mlast = mg; busy = 1; n = 0;
          m_wr = ifc.req_wr[mg];
          m_addr = mg == 1 ? ifc.req_addr1 : ifc.req_addr0;
          m_wdata = mg == 1 ? ifc.req_wdata1 : ifc.req_wdata0;
          e_s1 = {~m_wr, m_addr, 12'h000}; e_s1v = 1;
          e_s2 = m_wr ? {m_wdata, 4'h0} : 20'h0; e_s2v = m_wr;
        end
      end
    end
  end
  bit chk_on = 0;
  always @(negedge clk) if (chk_on) begin
    chk("slot1", s1, e_s1);
    chk("slot1_valid", s1v, e_s1v);
    chk("slot2", s2, e_s2);
    chk("slot2_valid", s2v, e_s2v);
    chk("done", ifc.done, e_done);
    chk("err", ifc.err, e_err);
    chk("rdata", ifc.rdata, e_rdata);
  end
  bit last_stb, rnd_on = 0;
  int fc = 0;
  task automatic codec();
    if (busy && !m_wr && $urandom % 3 != 0) begin
      in1 = {1'b0, m_addr, 12'h000}; in1v = 1;
      in2 = {16'($urandom), 4'h0}; in2v = $urandom % 4 != 0;
    end else begin
      in1 = {1'b0, 7'($urandom), 12'h000}; in1v = 1'($urandom);
      in2 = 20'($urandom); in2v = 1'($urandom);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    last_stb = strobe;
    #2;
    if (last_stb && rnd_on) codec();
    fc = (fc + 1) % FR;
    strobe = (fc == FR - 1);
  endtask
  task automatic to_strobe(input string nm);
    int k = 0;
    do begin tick(); k++; end while (!last_stb && k < FR + 2);
    if (!last_stb) expire(nm);
  endtask
  task automatic wait_done(input int i, input string nm);
    int k = 0;
    do begin tick(); k++; end while (!ifc.done[i] && k < 8 * FR);
    if (!ifc.done[i]) expire(nm);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k, nst, ndone;
    bit saw;
    ifc.req = 0; ifc.req_wr = 0; ifc.req_addr0 = 0; ifc.req_addr1 = 0;
    ifc.req_wdata0 = 0; ifc.req_wdata1 = 0;
    repeat (3) tick();
    chk_on = 1;
    tick();
    chk("rst_slot1", s1, 0); chk("rst_slot1_valid", s1v, 0);
    chk("rst_slot2", s2, 0); chk("rst_slot2_valid", s2v, 0);
    chk("rst_done", ifc.done, 0); chk("rst_err", ifc.err, 0); chk("rst_rdata", ifc.rdata, 0);
    rst_n = 1;
    // write from requester 0
    to_strobe("t1_align");
    ifc.req_wr[0] = 1; ifc.req_addr0 = MASTER_VOL; ifc.req_wdata0 = 16'h0808; ifc.req[0] = 1;
    to_strobe("t1_grant");
    chk("t1_slot1", s1, 20'h02000); chk("t1_slot2", s2, 20'h08080);
    chk("t1_s1v", s1v, 1); chk("t1_s2v", s2v, 1);
    to_strobe("t1_issue");
    chk("t1_done", ifc.done, 2'b01); chk("t1_err", ifc.err, 0);
    chk("t1_s1v_off", s1v, 0); chk("t1_s2v_off", s2v, 0);
    ifc.req[0] = 0;
    tick();
    chk("t1_done_pulse", ifc.done, 0);
    // read from requester 1 answered one frame later
    ifc.req_wr[1] = 0; ifc.req_addr1 = POWERDOWN; ifc.req[1] = 1;
    to_strobe("t2_grant");
    chk("t2_slot1", s1, 20'hA6000); chk("t2_s1v", s1v, 1); chk("t2_s2v", s2v, 0);
    to_strobe("t2_issue");
    in1 = 20'h26000; in1v = 1; in2 = 20'h000F0; in2v = 1;
    to_strobe("t2_resp");
    chk("t2_done", ifc.done, 2'b10); chk("t2_rdata", ifc.rdata, 16'h000F); chk("t2_err", ifc.err, 0);
    ifc.req[1] = 0; in1v = 0; in2v = 0;
    // both requesting writes continuously
    ifc.req_wr = 2'b11; ifc.req_addr0 = PCM_VOL; ifc.req_wdata0 = 16'h1111;
    ifc.req_addr1 = MASTER_VOL; ifc.req_wdata1 = 16'h2222; ifc.req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      nst = 0; k = 0;
      do begin tick(); k++; if (last_stb) nst++; end while (ifc.done == 0 && k < 4 * FR);
      if (ifc.done == 0) expire("t4_done");
      chk("t4_grant", ifc.done, (j % 2) ? 2'b10 : 2'b01);
      chk("t4_frames", nst, 2);
      chk("t4_idle", s1v, 0);
    end
    ifc.req = 0;
    // read timeout: codec answers for a different register
    ifc.req_wr[0] = 0; ifc.req_addr0 = VID0; ifc.req[0] = 1;
    in1 = {1'b0, VID1, 12'h000}; in1v = 1; in2 = 20'h12340; in2v = 1;
    to_strobe("t3_grant");
    to_strobe("t3_issue");
    k = 0;
    do begin to_strobe("t3_wait"); k++; end while (!ifc.done[0] && k < TO + 3);
    chk("t3_frames", k, TO); chk("t3_done", ifc.done, 2'b01);
    chk("t3_err", ifc.err, 1); chk("t3_rdata", ifc.rdata, 0);
    ifc.req[0] = 0; in1v = 0; in2v = 0;
    // reset while waiting for a read response
    ifc.req_wr[0] = 0; ifc.req_addr0 = 7'h10; ifc.req[0] = 1;
    to_strobe("t5_grant");
    to_strobe("t5_issue");
    repeat (5) tick();
    rst_n = 0;
    #1;
    chk("t5_slot1", s1, 0); chk("t5_s1v", s1v, 0); chk("t5_slot2", s2, 0); chk("t5_s2v", s2v, 0);
    chk("t5_done", ifc.done, 0); chk("t5_err", ifc.err, 0); chk("t5_rdata", ifc.rdata, 0);
    ifc.req = 0;
    saw = 0;
    repeat (2 * FR) begin tick(); if (ifc.done != 0) saw = 1; end
    chk("t5_no_done", saw, 0);
    rst_n = 1;
    ifc.req_wr[1] = 1; ifc.req_addr1 = VID1; ifc.req_wdata1 = 16'hBEEF; ifc.req[1] = 1;
    wait_done(1, "t5_fresh");
    chk("t5_fresh_done", ifc.done, 2'b10); chk("t5_fresh_err", ifc.err, 0);
    ifc.req[1] = 0;
    // request raised mid-frame waits for the strobe
    to_strobe("t6_align");
    repeat (10) tick();
    ifc.req_wr[0] = 1; ifc.req_addr0 = MASTER_VOL; ifc.req_wdata0 = 16'h0101; ifc.req[0] = 1;
    k = 0;
    do begin
      tick(); k++;
      if (!last_stb) chk("t6_hold", s1v, 0);
    end while (!last_stb && k < FR + 2);
    chk("t6_grant_s1v", s1v, 1); chk("t6_grant_slot1", s1, 20'h02000);
    wait_done(0, "t6_done");
    ifc.req[0] = 0;
    // random traffic with a randomly answering codec
    rnd_on = 1; ndone = 0;
    repeat (8000) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (ifc.req[i] && ifc.done[i]) begin ifc.req[i] = 0; ndone++; end
        else if (!ifc.req[i] && $urandom % 16 == 0) begin
          ifc.req_wr[i] = 1'($urandom);
          if (i == 0) begin ifc.req_addr0 = {6'($urandom), 1'b0}; ifc.req_wdata0 = 16'($urandom); end
          else begin ifc.req_addr1 = {6'($urandom), 1'b0}; ifc.req_wdata1 = 16'($urandom); end
          ifc.req[i] = 1;
        end
    end
    for (int j = 0; j < 50 * FR && ifc.req != 0; j++) begin
      tick();
      for (int i = 0; i < 2; i++) if (ifc.req[i] && ifc.done[i]) begin ifc.req[i] = 0; ndone++; end
    end
    if (ifc.req != 0) expire("drain");
    chk("rnd_activity", ndone >= 20, 1);
    repeat (4 * FR) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ac97_reg_arbiter.md
# ac97_reg_arbiter

- Shares the AC-link codec register command channel (output slots 1/2) between two requesters.
  - Requesters are the power-up configuration sequencer and a runtime control block (volume, status polling).
- Issues at most one register command per frame, aligned to `ac97_strobe`.
- Matches codec read responses from input slots 1/2 and returns completion, read data and timeout error to the requester.
- Sits between the requesters and the AC-link framer; its slot1/slot2 outputs feed the framer's slot inputs directly.

## Interface
Parameters:
- `TIMEOUT_FRAMES`, default 4: strobes to wait for a read response before signalling an error (range 2..15).

Ports:
- `ac97_bitclk` in 1: the single clock, codec bit clock.
- `ac97_rst_b` in 1: reset; asynchronous assert, active-low.
- `ac97_strobe` in 1: one-cycle frame boundary pulse from the framer.
- `req[1:0]` in 2: per-requester request level.
- `req_wr[1:0]` in 2: 1 = write, 0 = read.
- `req_addr0`, `req_addr1` in 7 each: codec register index (even values only).
- `req_wdata0`, `req_wdata1` in 16 each: write data.
- `done[1:0]` out 2: one-cycle completion pulse per requester.
- `err` out 1: qualifies `done`; 1 = read timed out.
- `rdata` out 16: read data, valid with `done`.
- `ac97_out_slot1` out 20 and `ac97_out_slot1_valid` out 1: command address slot.
- `ac97_out_slot2` out 20 and `ac97_out_slot2_valid` out 1: command data slot.
- `ac97_in_slot1` in 20 and `ac97_in_slot1_valid` in 1: status address returned by the codec, stable at `ac97_strobe`.
- `ac97_in_slot2` in 20 and `ac97_in_slot2_valid` in 1: status data returned by the codec.

## Operation
- Requester contract:
  - Raise `req[i]` with wr/addr/wdata stable.
  - Hold all of them until `done[i]`.
  - Drop `req[i]` no later than the cycle after `done[i]`.
- Arbitration:
  - Two-way round robin, evaluated only on a strobe cycle while IDLE.
  - A `last` pointer records the most recent grant; on contention the requester other than `last` wins. `last` resets to 1, so requester 0 wins the first contention.
- Slot encoding:
  - `slot1 = {~wr, addr[6:0], 12'h000}`.
  - Write: `slot2 = {wdata, 4'h0}`, slot2 valid = 1.
  - Read: `slot2 = 20'h0`, slot2 valid = 0.
- State machine:
  - IDLE: no valid slots. On a strobe with any `req`, grant, latch the command and load slot outputs → ISSUE.
  - ISSUE: slot outputs held for exactly one frame. On the next strobe, clear slot valids and slots to 0.
    - Write: pulse `done[g]`, `err = 0` → IDLE.
    - Read: load the timeout counter → WAIT_RD.
  - WAIT_RD: on each strobe, test the response.
    - Hit when `ac97_in_slot1_valid = 1`, `ac97_in_slot1[18:12] == addr` and `ac97_in_slot2_valid = 1`.
    - On hit: `rdata = ac97_in_slot2[19:4]`, pulse `done[g]`, `err = 0` → IDLE.
    - On miss: decrement the counter. When it reaches 0, pulse `done[g]` with `err = 1` and `rdata = 0` → IDLE.
    - Non-matching responses are ignored.
- `done`, `err` and `rdata` are registered.
  - `rdata` and `err` hold their value until the next `done`.
  - `err` reads 0 whenever the last done was a write.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE, `last = 1`, timeout counter 0.
- Reset asserted mid-operation:
  - Outputs clear immediately, asynchronously.
  - The pending command is dropped and no `done` is issued.
  - Requesters must re-request.
- Slot outputs change only on the posedge where `ac97_strobe = 1`. They are therefore stable for the whole following frame (framer bits 1..255).
- Write latency: the strobe after the issue strobe, i.e. `done` one cycle after the second strobe counting from the grant. This is 256 bit clocks after the grant.
- Read latency:
  - Minimum: the second strobe after grant plus one cycle (a codec answering in the next frame).
  - Maximum: `TIMEOUT_FRAMES` strobes after issue completes.
- Requests not aligned with a strobe wait for the next strobe. Maximum wait for the losing requester is one full transaction.
- A `done` and a new grant never occur in the same cycle. The earliest regrant is at the strobe after `done`, so the channel issues at most one command every two frames.
- A `req` that drops before `done` is a protocol violation. The transaction still completes and `done` pulses.

## Structure
- Shared package `ac97_pkg` holds:
  - Slot field constants: RW bit 19, address [18:12], data [19:4].
  - Codec register index constants: `AC97_REG_RESET = 7'h00`, `MASTER_VOL = 7'h02`, `PCM_VOL = 7'h18`, `POWERDOWN = 7'h26`, `VID0 = 7'h7C`, `VID1 = 7'h7E`.
  - The state enum: IDLE, ISSUE, WAIT_RD.
- One sub-module, `ac97_rr_arb2`: the two-way round-robin grant with the `last` pointer, advanced by an enable input.

## Test plan
- Write from requester 0, `req_addr0 = 7'h02`, `wdata = 16'h0808`:
  - The frame after the grant carries `slot1 = 20'h02000`, `slot2 = 20'h08080`, both valids 1.
  - `done[0]` pulses at the following strobe + 1 with `err = 0`.
  - Both valids are 0 in the next frame.
- Read from requester 1, `addr = 7'h26`; the model codec returns `in_slot1 = 20'h26000` and `in_slot2 = 20'h000F0` one frame later:
  - `done[1]` with `rdata = 16'h000F`, `err = 0`.
  - During the command frame, `slot1 = 20'hA6000` and `slot2_valid = 0`.
- Read of `7'h7C` with no matching response (the model returns `addr 7'h7E`):
  - `done` fires `TIMEOUT_FRAMES` (4) strobes after issue completes, with `err = 1` and `rdata = 0`.
- Both `req` bits asserted continuously with writes:
  - Grants alternate 0, 1, 0, 1.
  - Every command occupies exactly one frame.
  - There is one idle frame (valids 0) between commands.
- Drive `ac97_rst_b` low during WAIT_RD:
  - All outputs are 0 within the same cycle and no `done` pulses.
  - After release, a fresh request completes normally.
- `req[0]` raised 10 cycles after a strobe:
  - No slot change until the next strobe.
  - The grant occurs exactly on that strobe edge.
